// File: rtl/mul_div_sequencer.sv
// Sequential 32x32 multiply / divide unit (MULTU, MULT, DIVU, DIV) for the EX stage.
// Build option: define MULDIV_EARLY_OUT_EN to end multiplies once the remaining multiplier bits are zero.
module mul_div_sequencer (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Start,
  input  logic [1:0]  Op,
  input  logic [31:0] OpA,
  input  logic [31:0] OpB,
  input  logic        Abort,
  output logic        Busy,
  output logic        Done,
  output logic        HI_LO_Write,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        DivByZero
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    ITER = 3'd2,
    SIGN = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t      state_r, state_s, fsm_next_s;
  logic        is_div_r, res_neg_r, rem_neg_r;
  logic [63:0] acc_r, mcand_r;
  logic [31:0] b_r;
  logic [5:0]  cnt_r;
  logic        busy_r, done_r, dbz_r;
  logic [31:0] hi_r, lo_r;

  logic [63:0] acc_step_s, mcand_step_s, prod_s;
  logic [31:0] b_step_s, diff_s, hi_fix_s, lo_fix_s, raw_a_s;
  logic [32:0] trial_s;
  logic [5:0]  iter_cnt_s;
  logic        start_ok_s, dbz_s, write_s, a_neg_s, b_neg_s;

  function automatic logic [31:0] neg_if(input logic [31:0] v, input logic neg);
    return neg ? (32'd0 - v) : v;
  endfunction

`ifdef MULDIV_EARLY_OUT_EN
  function automatic logic [5:0] active_bits(input logic [31:0] v);
    logic [5:0] k;
    k = 6'd0;
    for (int i = 0; i < 32; i++) begin
      if (v[i]) k = 6'(i + 1);
      else k = k;
    end
    return k;
  endfunction
`endif

  // Operand signs, start qualification and step count chosen in LOAD.
  always_comb begin
    a_neg_s    = Op[0] & OpA[31];
    b_neg_s    = Op[0] & OpB[31];
    start_ok_s = (state_r == IDLE) && Start && !Abort;
    dbz_s      = is_div_r && (b_r == 32'd0);
`ifdef MULDIV_EARLY_OUT_EN
    iter_cnt_s = is_div_r ? 6'd32 : active_bits(b_r);
`else
    iter_cnt_s = 6'd32;
`endif
  end

  // One radix-2 step: shift-add multiply or restoring divide.
  always_comb begin
    acc_step_s   = acc_r;
    mcand_step_s = {mcand_r[62:0], 1'b0};
    b_step_s     = b_r;
    trial_s      = {acc_r[63:32], mcand_r[31]};
    diff_s       = trial_s[31:0] - b_r;
    if (is_div_r) begin
      // The partial remainder stays below the divisor, so 32 bits of the difference suffice.
      if (trial_s >= {1'b0, b_r}) begin
        acc_step_s = {diff_s, acc_r[30:0], 1'b1};
      end else begin
        acc_step_s = {trial_s[31:0], acc_r[30:0], 1'b0};
      end
    end else begin
      b_step_s = {1'b0, b_r[31:1]};
      if (b_r[0]) begin
        acc_step_s = acc_r + mcand_r;
      end else begin
        acc_step_s = acc_r;
      end
    end
  end

  // Sign correction applied to the value produced by the final step.
  always_comb begin
    prod_s   = res_neg_r ? (64'd0 - acc_step_s) : acc_step_s;
    raw_a_s  = neg_if(mcand_r[31:0], rem_neg_r);
    if (is_div_r) begin
      hi_fix_s = neg_if(acc_step_s[63:32], rem_neg_r);
      lo_fix_s = neg_if(acc_step_s[31:0], res_neg_r);
    end else begin
      hi_fix_s = prod_s[63:32];
      lo_fix_s = prod_s[31:0];
    end
  end

  // Next-state logic; SIGN performs the last step so ITER+SIGN together span the step count.
  always_comb begin
    fsm_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_ok_s) fsm_next_s = LOAD;
        else fsm_next_s = IDLE;
      end
      LOAD: begin
        if (dbz_s || (iter_cnt_s == 6'd0)) fsm_next_s = DONE;
        else if (iter_cnt_s == 6'd1) fsm_next_s = SIGN;
        else fsm_next_s = ITER;
      end
      ITER: begin
        if (cnt_r <= 6'd2) fsm_next_s = SIGN;
        else fsm_next_s = ITER;
      end
      SIGN:    fsm_next_s = DONE;
      DONE:    fsm_next_s = IDLE;
      default: fsm_next_s = IDLE;
    endcase
    state_s = Abort ? IDLE : fsm_next_s;
    write_s = (state_s == DONE);
  end

  // State register.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) state_r <= IDLE;
    else      state_r <= state_s;
  end

  // Operand capture and iteration datapath.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      is_div_r  <= 1'b0;
      res_neg_r <= 1'b0;
      rem_neg_r <= 1'b0;
      acc_r     <= 64'd0;
      mcand_r   <= 64'd0;
      b_r       <= 32'd0;
      cnt_r     <= 6'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start_ok_s) begin
            is_div_r  <= Op[1];
            mcand_r   <= {32'd0, neg_if(OpA, a_neg_s)};
            b_r       <= neg_if(OpB, b_neg_s);
            res_neg_r <= a_neg_s ^ b_neg_s;
            rem_neg_r <= a_neg_s;
          end
        end
        LOAD: begin
          acc_r <= 64'd0;
          cnt_r <= iter_cnt_s;
        end
        ITER, SIGN: begin
          acc_r   <= acc_step_s;
          mcand_r <= mcand_step_s;
          b_r     <= b_step_s;
          cnt_r   <= cnt_r - 6'd1;
        end
        default: cnt_r <= cnt_r;
      endcase
    end
  end

  // Registered outputs, decided from the state being entered.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
      dbz_r  <= 1'b0;
      hi_r   <= 32'd0;
      lo_r   <= 32'd0;
    end else begin
      busy_r <= (state_s != IDLE);
      done_r <= write_s;
      dbz_r  <= write_s && (state_r == LOAD) && dbz_s;
      if (write_s && (state_r == LOAD)) begin
        // Shortcut from LOAD: divide by zero, or an early-out multiply by zero.
        hi_r <= dbz_s ? raw_a_s : 32'd0;
        lo_r <= dbz_s ? 32'hFFFF_FFFF : 32'd0;
      end else if (write_s) begin
        hi_r <= hi_fix_s;
        lo_r <= lo_fix_s;
      end
    end
  end

  assign Busy        = busy_r;
  assign Done        = done_r;
  assign HI_LO_Write = done_r;
  assign DivByZero   = dbz_r;
  assign HI          = hi_r;
  assign LO          = lo_r;

endmodule

// File: tb/tb_mul_div_sequencer.sv
// Self-checking bench for mul_div_sequencer: per-cycle comparison against a cycle-count model
// built from plain arithmetic, plus hand-computed literal cases and randomized operations.
module tb_mul_div_sequencer;

  logic        Clk, Rst, Start, Abort;
  logic [1:0]  Op;
  logic [31:0] OpA, OpB;
  logic        Busy, Done, HI_LO_Write, DivByZero;
  logic [31:0] HI, LO;

  int   checks   = 0;
  int   failures = 0;
  logic chk_en   = 1'b0;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    logic [6:0]  lat;
  } res_t;

  mul_div_sequencer dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Op(Op), .OpA(OpA), .OpB(OpB), .Abort(Abort),
    .Busy(Busy), .Done(Done), .HI_LO_Write(HI_LO_Write), .HI(HI), .LO(LO), .DivByZero(DivByZero)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Result and latency of one operation, straight from the arithmetic definition.
  function automatic res_t model_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    res_t r;
    logic [63:0] p;
`ifdef MULDIV_EARLY_OUT_EN
    logic [31:0] mag;
    int k;
`endif
    r = '0;
    if (op[1] == 1'b0) begin
      if (op[0]) p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
      else       p = {32'd0, a} * {32'd0, b};
      r.hi = p[63:32];
      r.lo = p[31:0];
`ifdef MULDIV_EARLY_OUT_EN
      mag = (op[0] && b[31]) ? (32'd0 - b) : b;
      k = 0;
      for (int i = 0; i < 32; i++) if (mag[i]) k = i + 1;
      r.lat = 7'(2 + k);
`else
      r.lat = 7'd34;
`endif
    end else if (b == 32'd0) begin
      r.hi = a; r.lo = 32'hFFFF_FFFF; r.dbz = 1'b1; r.lat = 7'd2;
    end else if (op[0] == 1'b0) begin
      r.lo = a / b; r.hi = a % b; r.lat = 7'd34;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      r.lo = 32'h8000_0000; r.hi = 32'd0; r.lat = 7'd34;
    end else begin
      r.lo = 32'($signed(a) / $signed(b));
      r.hi = 32'($signed(a) % $signed(b));
      r.lat = 7'd34;
    end
    return r;
  endfunction

  // Cycle model: phase counts cycles since Start was taken (0 = idle).
  int          m_phase;
  res_t        pend;
  logic [31:0] m_hi, m_lo;

  always @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      m_phase <= 0; pend <= '0; m_hi <= 32'd0; m_lo <= 32'd0;
    end else if (Abort) begin
      m_phase <= 0;
    end else if (m_phase == 0) begin
      if (Start) begin
        pend    <= model_op(Op, OpA, OpB);
        m_phase <= 1;
      end
    end else if (m_phase == int'(pend.lat)) begin
      m_phase <= 0;
    end else begin
      m_phase <= m_phase + 1;
      if (m_phase + 1 == int'(pend.lat)) begin
        m_hi <= pend.hi;
        m_lo <= pend.lo;
      end
    end
  end

  logic exp_done;
  assign exp_done = (m_phase != 0) && (m_phase == int'(pend.lat));

  // Compare every output against the model on each falling edge.
  always @(negedge Clk) begin
    if (chk_en) begin
      check("cyc_busy", 64'(Busy), 64'(m_phase != 0));
      check("cyc_done", 64'(Done), 64'(exp_done));
      check("cyc_hlw", 64'(HI_LO_Write), 64'(exp_done));
      check("cyc_dbz", 64'(DivByZero), 64'(exp_done && pend.dbz));
      check("cyc_hi", 64'(HI), 64'(m_hi));
      check("cyc_lo", 64'(LO), 64'(m_lo));
    end
  end

  // Issue one operation (called #1 after a rising edge) and wait, bounded, for Done.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic noise, output logic [31:0] hi, output logic [31:0] lo,
                        output logic dbz, output int lat);
    res_t e;
    e = model_op(op, a, b);
    Op = op; OpA = a; OpB = b; Start = 1'b1;
    lat = -1; hi = 32'd0; lo = 32'd0; dbz = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      @(posedge Clk); #1;
      Start = noise && ($urandom_range(0, 3) == 0);
      if (Start) begin
        OpA = $urandom; OpB = $urandom; Op = 2'($urandom_range(0, 3));
      end
      @(negedge Clk);
      if (Done) begin
        lat = c; hi = HI; lo = LO; dbz = DivByZero;
        break;
      end
    end
    @(posedge Clk); #1;
    Start = 1'b0;
    check({tag, "_lat"}, 64'(lat), 64'(e.lat));
  endtask

  task automatic do_lit(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] xhi, input logic [31:0] xlo, input logic xdbz, input int xlat);
    logic [31:0] hi, lo;
    logic        dbz;
    int          lat;
    res_t        e;
    e = model_op(op, a, b);
    check({tag, "_model_hi"}, 64'(e.hi), 64'(xhi));
    check({tag, "_model_lo"}, 64'(e.lo), 64'(xlo));
    run_op(tag, op, a, b, 1'b0, hi, lo, dbz, lat);
    check({tag, "_hi"}, 64'(hi), 64'(xhi));
    check({tag, "_lo"}, 64'(lo), 64'(xlo));
    check({tag, "_dbz"}, 64'(dbz), 64'(xdbz));
    check({tag, "_lat_lit"}, 64'(lat), 64'(xlat));
  endtask

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] hi, lo;
    logic        dbz;
    int          lat, done_seen;
    res_t        e;
    logic [1:0]  rop;
    logic [31:0] ra, rb;

    Rst = 1'b0; Start = 1'b0; Abort = 1'b0; Op = 2'b00; OpA = 32'd0; OpB = 32'd0;
    repeat (3) @(posedge Clk);
    #1;
    check("rst_busy", 64'(Busy), 64'd0);
    check("rst_done", 64'(Done), 64'd0);
    check("rst_hlw", 64'(HI_LO_Write), 64'd0);
    check("rst_dbz", 64'(DivByZero), 64'd0);
    check("rst_hi", 64'(HI), 64'd0);
    check("rst_lo", 64'(LO), 64'd0);
    chk_en = 1'b1;
    Rst = 1'b1;

    // Started in the same cycle reset is released.
    do_lit("multu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 34);
    do_lit("mult_neg", 2'b01, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 34);
    do_lit("div_neg", 2'b11, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 34);
    do_lit("divu_zero", 2'b10, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF, 1'b1, 2);
    do_lit("div_zero_neg", 2'b11, 32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 1'b1, 2);
    do_lit("div_ovf", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, 34);

    // Abort mid-multiply; a second Start while busy must be dropped.
    Op = 2'b00; OpA = 32'h1234_5678; OpB = 32'h9ABC_DEF0; Start = 1'b1; done_seen = 0;
    for (int c = 1; c <= 45; c++) begin
      @(posedge Clk); #1;
      Start = (c == 5);
      Abort = (c == 10);
      if (c == 5) begin
        Op = 2'b10; OpA = 32'd99; OpB = 32'd0;
      end
      @(negedge Clk);
      if (Done) done_seen++;
      if (c == 11) begin
        check("abort_busy", 64'(Busy), 64'd0);
        check("abort_hi", 64'(HI), 64'd0);
        check("abort_lo", 64'(LO), 64'h8000_0000);
      end
    end
    check("abort_no_done", 64'(done_seen), 64'd0);
    @(posedge Clk); #1;

    // Reset in the middle of a divide.
    Op = 2'b10; OpA = 32'd1000; OpB = 32'd7; Start = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge Clk); #1;
      Start = 1'b0;
    end
    #2 Rst = 1'b0;
    #1;
    check("midrst_busy", 64'(Busy), 64'd0);
    check("midrst_done", 64'(Done), 64'd0);
    check("midrst_hlw", 64'(HI_LO_Write), 64'd0);
    check("midrst_dbz", 64'(DivByZero), 64'd0);
    check("midrst_hi", 64'(HI), 64'd0);
    check("midrst_lo", 64'(LO), 64'd0);
    repeat (2) @(negedge Clk);
    @(posedge Clk); #1;
    Rst = 1'b1;
    do_lit("multu_3x5", 2'b00, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0, 34);

`ifdef MULDIV_EARLY_OUT_EN
    do_lit("eo_5x3", 2'b00, 32'd5, 32'd3, 32'd0, 32'd15, 1'b0, 4);
    do_lit("eo_5x0", 2'b00, 32'd5, 32'd0, 32'd0, 32'd0, 1'b0, 2);
    do_lit("eo_mult_m1", 2'b01, 32'd9, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF7, 1'b0, 3);
`else
    do_lit("full_5x3", 2'b00, 32'd5, 32'd3, 32'd0, 32'd15, 1'b0, 34);
    do_lit("full_5x0", 2'b00, 32'd5, 32'd0, 32'd0, 32'd0, 1'b0, 34);
    do_lit("full_mult_m1", 2'b01, 32'd9, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF7, 1'b0, 34);
`endif

    // Randomized operations with Start noise while busy.
    for (int n = 0; n < 60; n++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = rnd_operand();
      rb  = rnd_operand();
      e   = model_op(rop, ra, rb);
      run_op("rand", rop, ra, rb, 1'($urandom_range(0, 1)), hi, lo, dbz, lat);
      check("rand_hi", 64'(hi), 64'(e.hi));
      check("rand_lo", 64'(lo), 64'(e.lo));
      check("rand_dbz", 64'(dbz), 64'(e.dbz));
      repeat ($urandom_range(0, 2)) begin
        @(posedge Clk); #1;
      end
    end

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mul_div_sequencer.md
MUL_DIV_SEQUENCER -- requirements
Module: mul_div_sequencer

Interface
REQ-001 SHALL provide Clk  input  1  sole clock; all state updates on its rising edge.
REQ-002 SHALL provide Rst  input  1  asynchronous, active-low reset.
REQ-003 SHALL provide Start  input  1  request from the EX stage; sampled only in IDLE.
REQ-004 SHALL provide Op  input  2  operation: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
REQ-005 SHALL provide OpA  input  32  multiplicand / dividend (rs).
REQ-006 SHALL provide OpB  input  32  multiplier / divisor (rt).
REQ-007 SHALL provide Abort  input  1  synchronous pipeline flush of the in-flight operation.
REQ-008 SHALL provide Busy  output  1  operation in flight; used as the pipeline stall request.
REQ-009 SHALL provide Done  output  1  one-cycle completion pulse.
REQ-010 SHALL provide HI_LO_Write  output  1  HI/LO register write enable; equals Done.
REQ-011 SHALL provide HI  output  32  product[63:32] or remainder.
REQ-012 SHALL provide LO  output  32  product[31:0] or quotient.
REQ-013 SHALL provide DivByZero  output  1  valid with Done; set when a divide had OpB==0.

Function
REQ-014 SHALL implement the FSM states IDLE, LOAD, ITER, SIGN and DONE.
REQ-015 IDLE & Start & !Abort SHALL capture Op, |OpA| and |OpB| (absolute values for signed ops, raw for unsigned), record the result signs, and go to LOAD.
REQ-016 LOAD SHALL clear the 64-bit accumulator, load the 6-bit iteration counter with 32, and go to ITER.
- Exception: a divide with OpB==0 goes directly to DONE.
REQ-017 ITER SHALL perform one radix-2 step per cycle (shift-add multiply or restoring divide), decrement the counter, and go to SIGN when the counter reaches 0.
REQ-018 SIGN SHALL apply the sign rules, register HI/LO, and go to DONE.
- MULT: two's-complement negation of the 64-bit product if the operand signs differ.
- DIV: quotient truncated toward zero; remainder takes the sign of the dividend.
REQ-019 DONE SHALL assert Done and HI_LO_Write for exactly one cycle, then return to IDLE.
REQ-020 Latency: Done SHALL be high exactly 34 cycles after the cycle in which Start was sampled.
- Exception: a divide by zero completes with Done high 2 cycles after Start.
REQ-021 Busy SHALL be high in LOAD, ITER, SIGN and DONE, and low only in IDLE.
REQ-022 Start asserted while not in IDLE SHALL be ignored, with no queuing.
REQ-023 Divide by zero SHALL produce HI=OpA, LO=0xFFFFFFFF and DivByZero=1; DivByZero SHALL be 0 for every other completion.
REQ-024 DIV 0x80000000 / 0xFFFFFFFF SHALL produce LO=0x80000000 and HI=0 with no error flag.
REQ-025 Abort SHALL force IDLE on the next edge from any state, suppress Done, and leave HI/LO unchanged.
- Abort and Start together in IDLE: Abort wins and Start is dropped.
REQ-026 HI and LO SHALL hold the last completed result until the next Done.
REQ-027 All outputs SHALL be registered, with no combinational path from any input to any output.

Reset
REQ-028 Rst low SHALL immediately force IDLE, Busy=0, Done=0, HI_LO_Write=0, DivByZero=0, HI=0, LO=0, and counter=0, including mid-operation.
REQ-029 The first Start SHALL be accepted on the first rising edge after Rst deasserts.

Configuration
REQ-030 The macro MULDIV_EARLY_OUT_EN SHALL control multiply early termination.
- Defined: multiplies leave ITER as soon as the remaining multiplier bits are all zero. Done then occurs 2+k cycles after Start, where k = (index of the highest set bit of |OpB|)+1; k=0 when OpB==0.
- Undefined: multiplies always take 32 iterations.
- Divides are unaffected in both cases.

Verification
REQ-031 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001, Done at cycle 34, Busy high for cycles 1-34.
REQ-032 MULT 0xFFFFFFFD x 7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB; DIV 0xFFFFFFF9 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-033 DIVU 7 / 0 -> Done at cycle 2, HI=7, LO=0xFFFFFFFF, DivByZero=1; DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0, DivByZero=0.
REQ-034 Abort at cycle 10 of a MULTU -> Busy low from cycle 11, no Done, HI/LO keep the prior result; a Start at cycle 5 of an operation is ignored.
REQ-035 Rst low at cycle 20 of a DIVU -> all outputs 0 immediately; after release, MULTU 3 x 5 -> LO=15 at cycle 34.
REQ-036 With MULDIV_EARLY_OUT_EN defined: MULTU 5 x 3 -> LO=15, HI=0, Done at cycle 4; MULTU 5 x 0 -> Done at cycle 2, LO=0.
